ps2_kbd_matrix: RTL

- Receives the serial PS/2 keyboard stream that mist_io emits on ps2_kbd_clk/ps2_kbd_data, all on clk_sys.
- Deframes the stream and decodes set-2 make/break codes, including the E0 and F0 prefixes.
- Maintains the SAM Coupé 9-row x 8-column key matrix, which the ULA port logic reads by row select.
- Also emits a per-key event strobe for the OSD and debug logic.

---
 rtl/ps2_kbd_matrix.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_matrix.sv
// PS/2 set-2 keyboard receiver feeding the SAM Coupe 9x8 key matrix; optional F-key controls under PS2_KBD_FKEY_EN.
// Latency: 4 clk_sys from the stop-bit falling edge to key_strobe (2 sync + DECODE + register); cols is combinational.
// Backpressure: none; the PS/2 source cannot be stalled, so each event is strobed once and the matrix holds the state.
module ps2_kbd_matrix #(
    parameter int TIMEOUT = 20000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    input  logic [8:0] row_sel,
    output logic [7:0] cols,
    output logic       key_strobe,
    output logic [8:0] key_code,
    output logic       key_pressed,
    output logic       frame_err,
    output logic       reset_key,
    output logic       nmi_key
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RECV, DECODE} state_t;

    state_t          state, state_nxt;
    logic            clk_s1, clk_s2, clk_d, data_s1, data_s2;
    logic            fall, timeout, frame_ok, err_nxt;
    logic [9:0]      shreg, frame;
    logic [3:0]      bit_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            ext, brk;
    logic [8:0][7:0] mtx;
    logic [8:0]      code;
    logic [7:0]      km;
    logic [7:0]      sel_or;

    // Returns {hit, row[3:0], col[2:0]} for a decoded {ext, scancode}.
    function automatic logic [7:0] key_map(input logic [8:0] c);
        logic [7:0] r;
        r = 8'h00;
        case (c)
            9'h012, 9'h059: r = {1'b1, 4'd0, 3'd0};
            9'h01A: r = {1'b1, 4'd0, 3'd1};
            9'h022: r = {1'b1, 4'd0, 3'd2};
            9'h021: r = {1'b1, 4'd0, 3'd3};
            9'h02A: r = {1'b1, 4'd0, 3'd4};
            9'h01C: r = {1'b1, 4'd1, 3'd0};
            9'h01B: r = {1'b1, 4'd1, 3'd1};
            9'h023: r = {1'b1, 4'd1, 3'd2};
            9'h02B: r = {1'b1, 4'd1, 3'd3};
            9'h034: r = {1'b1, 4'd1, 3'd4};
            9'h029: r = {1'b1, 4'd7, 3'd0};
            9'h014: r = {1'b1, 4'd7, 3'd1};
            9'h03A: r = {1'b1, 4'd7, 3'd2};
            9'h031: r = {1'b1, 4'd7, 3'd3};
            9'h032: r = {1'b1, 4'd7, 3'd4};
            9'h114: r = {1'b1, 4'd8, 3'd0};
            9'h175: r = {1'b1, 4'd8, 3'd1};
            9'h172: r = {1'b1, 4'd8, 3'd2};
            9'h16B: r = {1'b1, 4'd8, 3'd3};
            9'h174: r = {1'b1, 4'd8, 3'd4};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign fall     = clk_d & ~clk_s2;
    assign frame    = {data_s2, shreg[9:1]};
    assign frame_ok = (^frame[8:0]) & frame[9];
    assign timeout  = (state == RECV) && (tmo_cnt == TW'(TIMEOUT - 1));
    assign code     = {ext, shreg[7:0]};
    assign km       = key_map(code);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_d   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            state   <= IDLE;
        end else begin
            clk_s1  <= ps2_kbd_clk;
            clk_s2  <= clk_s1;
            clk_d   <= clk_s2;
            data_s1 <= ps2_kbd_data;
            data_s2 <= data_s1;
            state   <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: if (fall && !data_s2) state_nxt = RECV;
            RECV: begin
                if (fall && bit_cnt == 4'd9) begin
                    if (frame_ok) begin
                        state_nxt = DECODE;
                    end else begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            DECODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            ext         <= 1'b0;
            brk         <= 1'b0;
            mtx         <= '0;
            key_strobe  <= 1'b0;
            key_code    <= '0;
            key_pressed <= 1'b0;
            frame_err   <= 1'b0;
`ifdef PS2_KBD_FKEY_EN
            reset_key   <= 1'b0;
            nmi_key     <= 1'b0;
`endif
        end else begin
            key_strobe <= 1'b0;
            frame_err  <= err_nxt;
            tmo_cnt    <= (state != RECV || fall) ? '0 : tmo_cnt + 1'b1;
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == RECV && fall) begin
                shreg   <= frame;
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == DECODE) begin
                if (shreg[7:0] == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shreg[7:0] == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    key_strobe  <= 1'b1;
                    key_code    <= code;
                    key_pressed <= ~brk;
                    ext         <= 1'b0;
                    brk         <= 1'b0;
                    if (km[7]) mtx[km[6:3]][km[2:0]] <= ~brk;
`ifdef PS2_KBD_FKEY_EN
                    if (code == 9'h009) reset_key <= ~brk;
                    if (code == 9'h078) nmi_key   <= ~brk;
                    if (code == 9'h007 && !brk) mtx <= '0;
`endif
                end
            end
        end
    end

`ifndef PS2_KBD_FKEY_EN
    assign reset_key = 1'b0;
    assign nmi_key   = 1'b0;
`endif

    // Selected rows are ORed as pressed-high, which is the AND of the active-low columns.
    always_comb begin
        sel_or = '0;
        for (int r = 0; r < 9; r++) begin
            if (!row_sel[r]) sel_or = sel_or | mtx[r];
        end
    end

    assign cols = ~sel_or;
endmodule
